// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: operand register (E) feeding the ALU, writeback register (W), flags
module alu_exec_stage #(
   parameter int          DATA_W = 16,
   parameter int          RD_W   = 3,
   parameter logic [3:0]  OP_MAX = 4'hA
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_wordA,
   input  logic [DATA_W-1:0] i_wordB,
   input  logic [RD_W-1:0]   i_rd,
   input  logic              i_set_flags,
   output logic [3:0]        o_alu_opcode,
   output logic [DATA_W-1:0] o_alu_wordA,
   output logic [DATA_W-1:0] o_alu_wordB,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic [3:0]        i_alu_flags,
   output logic              o_wb_valid,
   input  logic              i_wb_ready,
   output logic [DATA_W-1:0] o_wb_data,
   output logic [RD_W-1:0]   o_wb_rd,
   output logic [3:0]        o_flags,
   output logic              o_illegal
);

   logic              e_valid;
   logic [3:0]        e_opcode;
   logic [DATA_W-1:0] e_word_a;
   logic [DATA_W-1:0] e_word_b;
   logic [RD_W-1:0]   e_rd;
   logic              e_set_flags;

   logic              w_valid;
   logic [DATA_W-1:0] w_data;
   logic [RD_W-1:0]   w_rd;

   logic              w_take;
   logic              e_adv;
   logic              accept;
   logic              e_illegal;

   // W can take new data when empty or being drained this cycle; E frees up when it advances.
   assign w_take    = !w_valid || i_wb_ready;
   assign e_adv     = e_valid && w_take;
   assign o_ready   = !e_valid || w_take;
   assign accept    = i_valid && o_ready;
   assign e_illegal = (e_opcode > OP_MAX);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         e_valid     <= 1'b0;
         e_opcode    <= '0;
         e_word_a    <= '0;
         e_word_b    <= '0;
         e_rd        <= '0;
         e_set_flags <= 1'b0;
      end else if (accept) begin
         e_valid     <= 1'b1;
         e_opcode    <= i_opcode;
         e_word_a    <= i_wordA;
         e_word_b    <= i_wordB;
         e_rd        <= i_rd;
         e_set_flags <= i_set_flags;
      end else if (e_adv) begin
         e_valid     <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         w_valid <= 1'b0;
         w_data  <= '0;
         w_rd    <= '0;
      end else if (e_adv) begin
         w_valid <= 1'b1;
         w_data  <= i_alu_result;
         w_rd    <= e_rd;
      end else if (i_wb_ready) begin
         w_valid <= 1'b0;
      end
   end

   // Flags commit on the same edge as W, so o_flags always matches the result in W.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_flags   <= 4'h0;
         o_illegal <= 1'b0;
      end else begin
         o_illegal <= e_adv && e_illegal;
         if (e_adv && e_set_flags && !e_illegal) begin
            o_flags <= i_alu_flags;
         end
      end
   end

   assign o_alu_opcode = e_opcode;
   assign o_alu_wordA  = e_word_a;
   assign o_alu_wordB  = e_word_b;
   assign o_wb_valid   = w_valid;
   assign o_wb_data    = w_data;
   assign o_wb_rd      = w_rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage with a behavioural ALU
module tb_alu_exec_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_opcode;
   logic [15:0] i_wordA;
   logic [15:0] i_wordB;
   logic [2:0]  i_rd;
   logic        i_set_flags;
   logic [3:0]  o_alu_opcode;
   logic [15:0] o_alu_wordA;
   logic [15:0] o_alu_wordB;
   logic [15:0] i_alu_result;
   logic [3:0]  i_alu_flags;
   logic        o_wb_valid;
   logic        i_wb_ready;
   logic [15:0] o_wb_data;
   logic [2:0]  o_wb_rd;
   logic [3:0]  o_flags;
   logic        o_illegal;

   alu_exec_stage #(.DATA_W(16), .RD_W(3), .OP_MAX(4'hA)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_opcode(i_opcode), .i_wordA(i_wordA), .i_wordB(i_wordB), .i_rd(i_rd),
      .i_set_flags(i_set_flags), .o_alu_opcode(o_alu_opcode), .o_alu_wordA(o_alu_wordA),
      .o_alu_wordB(o_alu_wordB), .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags),
      .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_data(o_wb_data),
      .o_wb_rd(o_wb_rd), .o_flags(o_flags), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // ALU stand-in: {zero, sign, overflow, carry, result}; illegal opcodes give result 0 and junk flags.
   function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      logic [15:0] r;
      logic        v;
      logic        c;
      t = '0; r = '0; v = 1'b0; c = 1'b0;
      case (op)
         4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'h1: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = ~a;
         4'h6: r = a << 1;
         4'h7: r = a >> 1;
         4'h8: r = a + 16'd1;
         4'h9: r = a - 16'd1;
         4'hA: r = b;
         default: return {4'hF, 16'h0000};
      endcase
      return {(r == 16'h0), r[15], v, c, r};
   endfunction

   logic [19:0] alu_out;
   assign alu_out      = alu_model(o_alu_opcode, o_alu_wordA, o_alu_wordB);
   assign i_alu_result = alu_out[15:0];
   assign i_alu_flags  = alu_out[19:16];

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  rd;
      logic [3:0]  flags;
      logic        ill;
   } sb_t;

   sb_t  sb[$];
   int   checks = 0;
   int   failures = 0;
   int   stall_cnt = 0;
   logic [3:0] model_flags = 4'h0;
   logic prev_take = 1'b1;
   logic prev_hold = 1'b0;
   logic [15:0] prev_data = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor samples at negedge; inputs seen here are the ones the next rising edge will use.
   always @(negedge i_clk) begin
      logic [19:0] m;
      logic        exp_ill;
      sb_t         head;
      sb_t         e;
      if (i_reset) begin
         sb.delete();
         model_flags = 4'h0;
         prev_take   = 1'b1;
         prev_hold   = 1'b0;
      end else begin
         exp_ill = o_wb_valid && prev_take && (sb.size() > 0) && sb[0].ill;
         check_eq("illegal_pulse", o_illegal, exp_ill);
         if (prev_hold && o_wb_valid) check_eq("wb_stable", o_wb_data, prev_data);
         if (o_wb_valid && i_wb_ready) begin
            if (sb.size() == 0) begin
               check_eq("wb_unexpected", o_wb_valid, 1'b0);
            end else begin
               head = sb.pop_front();
               check_eq("wb_data", o_wb_data, head.data);
               check_eq("wb_rd", o_wb_rd, head.rd);
               check_eq("wb_flags", o_flags, head.flags);
            end
         end
         if (i_valid && o_ready) begin
            m = alu_model(i_opcode, i_wordA, i_wordB);
            if (i_set_flags && (i_opcode <= 4'hA)) model_flags = m[19:16];
            e.data  = m[15:0];
            e.rd    = i_rd;
            e.flags = model_flags;
            e.ill   = (i_opcode > 4'hA);
            sb.push_back(e);
         end
         if (i_valid && !o_ready) stall_cnt++;
         prev_take = !o_wb_valid || i_wb_ready;
         prev_hold = o_wb_valid && !i_wb_ready;
         prev_data = o_wb_data;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] rd, input logic sf);
      logic acc;
      i_valid = 1'b1; i_opcode = op; i_wordA = a; i_wordB = b; i_rd = rd; i_set_flags = sf;
      for (int t = 0; t < 100; t++) begin
         @(negedge i_clk);
         acc = o_ready;
         @(posedge i_clk);
         #1;
         if (acc) begin
            i_valid = 1'b0;
            return;
         end
      end
      check_eq("send_timeout", acc, 1'b1);
      i_valid = 1'b0;
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge i_clk);
         #1;
         if (sb.size() == 0 && !o_wb_valid) done = 1'b1;
         @(posedge i_clk);
         #1;
      end
      check_eq("drain_timeout", done, 1'b1);
   endtask

   int s0;

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_opcode = '0; i_wordA = '0; i_wordB = '0;
      i_rd = '0; i_set_flags = 1'b0; i_wb_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check_eq("rst_ready", o_ready, 1'b1);
      check_eq("rst_wb_valid", o_wb_valid, 1'b0);
      check_eq("rst_wb_data", o_wb_data, 16'h0);
      check_eq("rst_alu_a", o_alu_wordA, 16'h0);
      i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check_eq("idle_ready", o_ready, 1'b1);
      check_eq("idle_wb_valid", o_wb_valid, 1'b0);
      check_eq("idle_flags", o_flags, 4'h0);
      check_eq("idle_illegal", o_illegal, 1'b0);

      // Single ADD with signed overflow
      i_wb_ready = 1'b1;
      send(4'h0, 16'h7FFF, 16'h0001, 3'd1, 1'b1);
      check_eq("lat_e_wb_valid", o_wb_valid, 1'b0);
      check_eq("lat_e_alu_a", o_alu_wordA, 16'h7FFF);
      @(posedge i_clk); #1;
      check_eq("add_wb_valid", o_wb_valid, 1'b1);
      check_eq("add_wb_data", o_wb_data, 16'h8000);
      check_eq("add_flags", o_flags, 4'b0110);
      @(posedge i_clk); #1;
      check_eq("add_consumed", o_wb_valid, 1'b0);

      // Back-to-back
      s0 = stall_cnt;
      send(4'h0, 16'd1, 16'd2, 3'd2, 1'b1);
      send(4'h1, 16'd5, 16'd7, 3'd3, 1'b1);
      check_eq("b2b_data0", o_wb_data, 16'd3);
      send(4'h4, 16'hFFFF, 16'hFFFF, 3'd4, 1'b0);
      check_eq("b2b_data1", o_wb_data, 16'hFFFE);
      check_eq("b2b_flags1", o_flags, 4'b0101);
      @(posedge i_clk); #1;
      check_eq("b2b_data2", o_wb_data, 16'h0);
      check_eq("b2b_flags2", o_flags, 4'b0101);
      check_eq("b2b_no_stall", stall_cnt - s0, 0);
      wait_drain();

      // Backpressure
      i_wb_ready = 1'b0;
      fork
         begin
            send(4'h2, 16'hF0F0, 16'hFF00, 3'd5, 1'b0);
            send(4'h3, 16'h0F00, 16'h00F0, 3'd6, 1'b0);
            send(4'h0, 16'd10, 16'd20, 3'd7, 1'b1);
         end
         begin
            repeat (4) @(posedge i_clk);
            #1;
            check_eq("bp_ready", o_ready, 1'b0);
            check_eq("bp_wb_valid", o_wb_valid, 1'b1);
            check_eq("bp_wb_data", o_wb_data, 16'hF000);
            check_eq("bp_e_opcode", o_alu_opcode, 4'h3);
            check_eq("bp_e_a", o_alu_wordA, 16'h0F00);
            i_wb_ready = 1'b1;
         end
      join
      wait_drain();

      // Illegal opcode must not touch flags
      send(4'h1, 16'd5, 16'd5, 3'd1, 1'b1);
      wait_drain();
      check_eq("pre_ill_flags", o_flags, 4'b1000);
      send(4'hC, 16'h1234, 16'h0001, 3'd2, 1'b1);
      @(posedge i_clk); #1;
      check_eq("ill_wb_valid", o_wb_valid, 1'b1);
      check_eq("ill_wb_data", o_wb_data, 16'h0);
      check_eq("ill_flags", o_flags, 4'b1000);
      check_eq("ill_pulse_hi", o_illegal, 1'b1);
      @(posedge i_clk); #1;
      check_eq("ill_pulse_lo", o_illegal, 1'b0);
      check_eq("ill_flags_hold", o_flags, 4'b1000);
      wait_drain();

      // Asynchronous reset with E and W both occupied
      i_wb_ready = 1'b0;
      send(4'h0, 16'd1, 16'd1, 3'd3, 1'b1);
      send(4'hF, 16'd2, 16'd2, 3'd4, 1'b1);
      check_eq("pre_rst_wb_valid", o_wb_valid, 1'b1);
      check_eq("pre_rst_flags", o_flags, 4'h0);
      #2;
      i_reset = 1'b1;
      #1;
      check_eq("arst_wb_valid", o_wb_valid, 1'b0);
      check_eq("arst_flags", o_flags, 4'h0);
      check_eq("arst_ready", o_ready, 1'b1);
      check_eq("arst_alu_op", o_alu_opcode, 4'h0);
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      i_wb_ready = 1'b1;
      @(posedge i_clk); #1;
      check_eq("post_rst_illegal", o_illegal, 1'b0);
      send(4'h0, 16'hFFFF, 16'h0001, 3'd5, 1'b1);
      @(posedge i_clk); #1;
      check_eq("post_rst_data", o_wb_data, 16'h0);
      check_eq("post_rst_flags", o_flags, 4'b1001);
      wait_drain();

      // Random ops under random backpressure, scoreboard-checked
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int k = 0; k < 60; k++) begin
               @(posedge i_clk); #1;
               i_wb_ready = 1'($urandom_range(0, 1));
            end
            i_wb_ready = 1'b1;
         end
      join
      i_wb_ready = 1'b1;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
